uart_rx_decoder: RTL and testbench

- UART receive path for the processor's protocol controllers. Counterpart of the transmit path.
- Oversamples the serial input at 16x and decodes 8N1 frames, LSB first.
- Pushes each valid byte into a 16-entry receive FIFO, which the bus side pops with rd.
- Reports framing errors, buffer overrun, and buffer full/empty/count.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_decoder_fifo.sv | 68 ++++++
 rtl/uart_rx_decoder.sv | 143 ++++++++++++++
 tb/tb_uart_rx_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// FSM state encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [3:0] LAST_SAMPLE = 4'd15;

endpackage

// File: rtl/uart_rx_decoder_fifo.sv
// rx_fifo: circular receive buffer with count, empty, full and sticky overrun.
// Ports: CLK, rst, push/push_data in, rd pop, err_clr, data_out/count/empty/full/overrun out.
module rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     rd,
  input  logic                     err_clr,
  output logic [7:0]               data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overrun
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;
  logic          wr;
  logic          drop;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));

  assign pop  = rd & ~empty;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign wr   = push & (~full | pop);
  assign drop = push & full & ~pop;

  assign data_out = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !wr) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_decoder.sv
// uart_rx_decoder: 16x oversampled 8N1 receiver feeding a receive FIFO.
// Ports: CLK, rst, rx, rd, err_clr in; data_out, buffer_*, frame_err, overrun, rx_busy out.
module uart_rx_decoder
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 54,
  parameter int DEPTH    = 16
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     rx,
  input  logic                     rd,
  input  logic                     err_clr,
  output logic [7:0]               data_out,
  output logic [$clog2(DEPTH):0]   buffer_count,
  output logic                     buffer_empty,
  output logic                     buffer_full,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     rx_busy
);

  localparam int TW = $clog2(BAUD_DIV);

  rx_state_t     state;
  logic [1:0]    sync;
  logic          rx_s;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    samp_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          push_stb;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rx_s = sync[1];

  // Held in IDLE so the sampling phase starts at the start edge.
  assign tick = (state != ST_IDLE) &&
                (tick_cnt == TW'(BAUD_DIV - 1));

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (state == ST_IDLE || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      samp_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      push_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push_stb <= 1'b0;
      if (err_clr) begin
        frame_err <= 1'b0;
      end
      if (tick) begin
        samp_cnt <= samp_cnt + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state    <= ST_START;
            samp_cnt <= '0;
          end
        end
        ST_START: begin
          if (tick && samp_cnt == MID_SAMPLE) begin
            if (!rx_s) begin
              state    <= ST_DATA;
              samp_cnt <= '0;
              bit_idx  <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (tick && samp_cnt == LAST_SAMPLE) begin
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick && samp_cnt == LAST_SAMPLE) begin
            if (rx_s) begin
              push_stb <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_busy = (state != ST_IDLE);

  rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .rst       (rst),
    .push      (push_stb),
    .push_data (shift),
    .rd        (rd),
    .err_clr   (err_clr),
    .data_out  (data_out),
    .count     (buffer_count),
    .empty     (buffer_empty),
    .full      (buffer_full),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Directed bench for uart_rx_decoder with a byte scoreboard.
// Frames are driven bit-serially; popped bytes are compared to the queue.
module tb_uart_rx_decoder;

  localparam int BD   = 4;
  localparam int BITC = 16 * BD;

  logic       CLK = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd;
  logic       err_clr;
  logic [7:0] data_out;
  logic [4:0] buffer_count;
  logic       buffer_empty;
  logic       buffer_full;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  uart_rx_decoder #(
    .BAUD_DIV(BD),
    .DEPTH   (16)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .rx           (rx),
    .rd           (rd),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .buffer_count (buffer_count),
    .buffer_empty (buffer_empty),
    .buffer_full  (buffer_full),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .rx_busy      (rx_busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] b,
                      input bit stop_hi,
                      input bit accept,
                      input bit pop_on_push);
    bit done;
    logic [7:0] e;
    done = 1'b0;
    if (accept) sb.push_back(b);
    hold(1'b0, BITC);
    for (int i = 0; i < 8; i++) hold(b[i], BITC);
    rx = stop_hi;
    for (int c = 0; c < BITC; c++) begin
      @(negedge CLK);
      if (pop_on_push && !done && dut.push_stb) begin
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        chk("pp_head", {24'h0, data_out}, {24'h0, e});
        rd   = 1'b1;
        done = 1'b1;
      end else begin
        rd = 1'b0;
      end
    end
    rd = 1'b0;
    if (pop_on_push) chk("pp_seen", {31'h0, done}, 32'h1);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    chk(tag, {24'h0, data_out}, {24'h0, e});
    rd = 1'b1;
    @(negedge CLK);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst     = 1'b1;
    rx      = 1'b1;
    rd      = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_count", 32'(buffer_count), 32'h0);
    chk("rst_empty", 32'(buffer_empty), 32'h1);
    chk("rst_full",  32'(buffer_full),  32'h0);
    chk("rst_ferr",  32'(frame_err),    32'h0);
    chk("rst_ovr",   32'(overrun),      32'h0);
    chk("rst_busy",  32'(rx_busy),      32'h0);
    chk("rst_data",  32'(data_out),     32'h0);
    rst = 1'b0;
    repeat (2) @(negedge CLK);

    send(8'hA5, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);
    chk("a5_count", 32'(buffer_count), 32'h1);
    chk("a5_data",  32'(data_out),     32'hA5);
    chk("a5_ferr",  32'(frame_err),    32'h0);
    pop_chk("a5_pop");
    chk("a5_cnt0",  32'(buffer_count), 32'h0);
    chk("a5_empty", 32'(buffer_empty), 32'h1);
    chk("a5_data0", 32'(data_out),     32'h0);

    hold(1'b0, 3 * BD);
    rx = 1'b1;
    chk("gl_busy", 32'(rx_busy), 32'h1);
    n = 0;
    while (rx_busy && n < 8 * BD) begin
      @(negedge CLK);
      n++;
    end
    chk("gl_idle",  32'(rx_busy),      32'h0);
    chk("gl_count", 32'(buffer_count), 32'h0);
    chk("gl_ferr",  32'(frame_err),    32'h0);
    chk("gl_ovr",   32'(overrun),      32'h0);

    send(8'h3C, 1'b0, 1'b0, 1'b0);
    hold(1'b0, BITC);
    chk("fe_ferr",  32'(frame_err),    32'h1);
    chk("fe_break", 32'(rx_busy),      32'h1);
    chk("fe_count", 32'(buffer_count), 32'h0);
    rx = 1'b1;
    repeat (4) @(negedge CLK);
    chk("fe_idle", 32'(rx_busy), 32'h0);
    pulse_clr();
    chk("fe_clr", 32'(frame_err), 32'h0);

    for (int i = 0; i < 17; i++) begin
      send(8'(i), 1'b1, (i < 16), 1'b0);
      if (i == 15) begin
        repeat (4) @(negedge CLK);
        chk("ov_full16", 32'(buffer_full),  32'h1);
        chk("ov_cnt16",  32'(buffer_count), 32'd16);
        chk("ov_pre",    32'(overrun),      32'h0);
      end
    end
    repeat (4) @(negedge CLK);
    chk("ov_flag",  32'(overrun),      32'h1);
    chk("ov_count", 32'(buffer_count), 32'd16);
    chk("ov_head",  32'(data_out),     32'h0);
    for (int i = 0; i < 16; i++) pop_chk("ov_pop");
    chk("ov_empty", 32'(buffer_empty), 32'h1);
    pulse_clr();
    chk("ov_clr", 32'(overrun), 32'h0);

    for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);
    chk("pp_full", 32'(buffer_full), 32'h1);
    send(8'h77, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge CLK);
    chk("pp_count", 32'(buffer_count), 32'd16);
    chk("pp_ovr",   32'(overrun),      32'h0);
    for (int i = 0; i < 15; i++) pop_chk("pp_pop");
    chk("pp_last", 32'(data_out), 32'h77);
    pop_chk("pp_pop");
    chk("pp_empty", 32'(buffer_empty), 32'h1);

    send(8'h11, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);
    chk("ar_pre", 32'(buffer_count), 32'h1);
    hold(1'b0, BITC);
    for (int i = 0; i < 4; i++) hold(i[0], BITC);
    hold(1'b0, BITC / 2);
    chk("ar_busy", 32'(rx_busy), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("ar_count", 32'(buffer_count), 32'h0);
    chk("ar_empty", 32'(buffer_empty), 32'h1);
    chk("ar_full",  32'(buffer_full),  32'h0);
    chk("ar_busy0", 32'(rx_busy),      32'h0);
    chk("ar_data",  32'(data_out),     32'h0);
    chk("ar_ferr",  32'(frame_err),    32'h0);
    rx = 1'b1;
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    repeat (2) @(negedge CLK);
    send(8'h5A, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);
    chk("5a_count", 32'(buffer_count), 32'h1);
    chk("5a_ferr",  32'(frame_err),    32'h0);
    pop_chk("5a_pop");
    chk("5a_empty", 32'(buffer_empty), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
